// File: rtl/lc_dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lc_dco_tune_ctrl
//  Purpose  : Tuning-word controller for the LC DCO switched-capacitor bank.
//             Three modes: static code, timed linear sweep, and SAR
//             binary-search calibration against an external edge counter.
//             Runs entirely in the reference-clock domain.
//  Revision : 1.0  initial release
// ============================================================================
module lc_dco_tune_ctrl #(
  parameter int SW_WIDTH    = 8,
  parameter int DWELL_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SW_WIDTH-1:0]    static_code,
  input  logic [SW_WIDTH-1:0]    sweep_start,
  input  logic [SW_WIDTH-1:0]    sweep_stop,
  input  logic [SW_WIDTH-1:0]    sweep_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [CNT_WIDTH-1:0]   target_count,
  input  logic [CNT_WIDTH-1:0]   meas_count,
  input  logic                   meas_valid,
  output logic                   meas_req,
  output logic [SW_WIDTH-1:0]    sw,
  output logic                   busy,
  output logic                   done,
  output logic                   locked,
  output logic [SW_WIDTH-1:0]    cal_code
);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SWEEP  = 2'd1;
  localparam logic [1:0] MODE_CAL    = 2'd2;

  localparam logic [SW_WIDTH-1:0]    SW_ONE    = {{(SW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SW_WIDTH-1:0]    SW_MSB    = {1'b1, {(SW_WIDTH-1){1'b0}}};
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SWEEP    = 3'd1,
    CAL_SET  = 3'd2,
    CAL_WAIT = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t state;

  // Configuration captured at start so later input changes have no effect
  logic [SW_WIDTH-1:0]    cfg_stop;
  logic [SW_WIDTH-1:0]    cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [CNT_WIDTH-1:0]   cfg_target;
  logic                   cal_run;

  // Sweep dwell counter and SAR working registers
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [SW_WIDTH-1:0]    trial;
  logic [SW_WIDTH-1:0]    work;

  logic [SW_WIDTH:0]      sweep_next;
  logic                   sweep_end;
  logic                   dwell_expired;
  logic                   keep_bit;
  logic [SW_WIDTH-1:0]    work_next;
  logic [SW_WIDTH-1:0]    step_eff;
  logic [DWELL_WIDTH-1:0] dwell_eff;

  // Zero step / zero dwell behave as one
  assign step_eff  = (sweep_step == '0) ? SW_ONE : sweep_step;
  assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

  // Next sweep code carries one extra bit so wrap-around is detectable
  assign sweep_next    = {1'b0, sw} + {1'b0, cfg_step};
  assign sweep_end     = sweep_next[SW_WIDTH] || (sweep_next[SW_WIDTH-1:0] > cfg_stop);
  assign dwell_expired = (dwell_cnt == (cfg_dwell - DWELL_ONE));

  // Too many DCO edges means the frequency is still high: keep the bit
  // (more capacitance lowers frequency)
  assign keep_bit  = (meas_count > cfg_target);
  assign work_next = keep_bit ? (work | trial) : work;

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sw         <= '0;
      cal_code   <= '0;
      meas_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      cfg_stop   <= '0;
      cfg_step   <= '0;
      cfg_dwell  <= '0;
      cfg_target <= '0;
      cal_run    <= 1'b0;
      dwell_cnt  <= '0;
      trial      <= '0;
      work       <= '0;
    end else if (abort && (state != IDLE)) begin
      // Abort wins over dwell expiry and measurement results; sw is frozen
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      meas_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          meas_req <= 1'b0;
          busy     <= 1'b0;
          if (start && (mode == MODE_SWEEP)) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            sw        <= sweep_start;
            cfg_stop  <= sweep_stop;
            cfg_step  <= step_eff;
            cfg_dwell <= dwell_eff;
            cal_run   <= 1'b0;
            dwell_cnt <= '0;
          end else if (start && (mode == MODE_CAL)) begin
            state      <= CAL_SET;
            busy       <= 1'b1;
            cfg_target <= target_count;
            cal_run    <= 1'b1;
            trial      <= SW_MSB;
            work       <= '0;
            locked     <= 1'b0;
          end else if (mode == MODE_STATIC) begin
            sw <= static_code;
          end
        end

        SWEEP: begin
          if (dwell_expired) begin
            if (sweep_end) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              sw        <= sweep_next[SW_WIDTH-1:0];
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_ONE;
          end
        end

        CAL_SET: begin
          sw       <= work | trial;
          meas_req <= 1'b1;
          state    <= CAL_WAIT;
        end

        CAL_WAIT: begin
          meas_req <= 1'b0;
          if (meas_valid) begin
            work <= work_next;
            if (trial[0]) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              trial <= trial >> 1;
              state <= CAL_SET;
            end
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (cal_run) begin
            sw       <= work;
            cal_code <= work;
            locked   <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          meas_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc_dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc_dco_tune_ctrl
//  Purpose  : Directed self-checking bench for lc_dco_tune_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc_dco_tune_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic        abort;
  logic [7:0]  static_code;
  logic [7:0]  sweep_start;
  logic [7:0]  sweep_stop;
  logic [7:0]  sweep_step;
  logic [15:0] dwell;
  logic [15:0] target_count;
  logic [15:0] meas_count;
  logic        meas_valid;
  logic        meas_req;
  logic [7:0]  sw;
  logic        busy;
  logic        done;
  logic        locked;
  logic [7:0]  cal_code;

  int checks   = 0;
  int failures = 0;

  lc_dco_tune_ctrl #(
    .SW_WIDTH   (8),
    .DWELL_WIDTH(16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .start       (start),
    .abort       (abort),
    .static_code (static_code),
    .sweep_start (sweep_start),
    .sweep_stop  (sweep_stop),
    .sweep_step  (sweep_step),
    .dwell       (dwell),
    .target_count(target_count),
    .meas_count  (meas_count),
    .meas_valid  (meas_valid),
    .meas_req    (meas_req),
    .sw          (sw),
    .busy        (busy),
    .done        (done),
    .locked      (locked),
    .cal_code    (cal_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One calibration run; abort_at = n aborts together with the n-th result
  task automatic run_cal(input int abort_at);
    int n;
    logic [7:0] exp_tr [8];
    exp_tr = '{8'd128, 8'd64, 8'd32, 8'd48, 8'd56, 8'd52, 8'd50, 8'd49};
    mode = 2'd2; target_count = 16'd900; start = 1'b1;
    step();
    start = 1'b0;
    chk("cal_busy_start", busy, 1);
    chk("cal_locked_cleared", locked, 0);
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (meas_req !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      chk("cal_meas_req", meas_req, 1);
      chk("cal_trial", sw, exp_tr[i]);
      step();
      chk("cal_req_one_cycle", meas_req, 0);
      repeat (3) step();
      meas_count = 16'(1000 - 2 * int'(sw));
      meas_valid = 1'b1;
      if (i + 1 == abort_at) abort = 1'b1;
      step();
      meas_valid = 1'b0;
      abort      = 1'b0;
      if (i + 1 == abort_at) begin
        chk("abort_busy", busy, 0);
        chk("abort_sw_hold", sw, 48);
        chk("abort_no_done", done, 0);
        chk("abort_locked", locked, 0);
        repeat (3) step();
        chk("abort_still_idle", busy, 0);
        chk("abort_sw_still", sw, 48);
        chk("abort_no_late_req", meas_req, 0);
        return;
      end
    end
    chk("cal_done_pulse", done, 1);
    chk("cal_locked_pre", locked, 0);
    step();
    chk("cal_done_fall", done, 0);
    chk("cal_busy_fall", busy, 0);
    chk("cal_locked", locked, 1);
    chk("cal_code", cal_code, 49);
    chk("cal_sw", sw, 49);
  endtask

  initial begin
    logic [7:0] exp_sweep [9];
    exp_sweep = '{8'd10, 8'd10, 8'd10, 8'd14, 8'd14, 8'd14, 8'd18, 8'd18, 8'd18};

    rst = 1'b1; mode = 2'd0; start = 1'b0; abort = 1'b0;
    static_code = 8'd127; sweep_start = '0; sweep_stop = '0; sweep_step = '0;
    dwell = '0; target_count = '0; meas_count = '0; meas_valid = 1'b0;

    // Reset then static mode
    repeat (3) begin
      step();
      chk("rst_sw", sw, 0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cal_code", cal_code, 0);
    chk("rst_meas_req", meas_req, 0);
    rst = 1'b0;
    step();
    chk("static_sw", sw, 127);
    chk("static_busy", busy, 0);
    chk("static_done", done, 0);

    // Linear sweep 10..20 step 4 dwell 3
    mode = 2'd1; sweep_start = 8'd10; sweep_stop = 8'd20; sweep_step = 8'd4;
    dwell = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    sweep_start = 8'd99; dwell = 16'd1;   // must be ignored while running
    for (int i = 0; i < 9; i++) begin
      chk("sweep_sw", sw, exp_sweep[i]);
      chk("sweep_busy", busy, 1);
      chk("sweep_no_done", done, 0);
      step();
    end
    chk("sweep_done", done, 1);
    chk("sweep_last_sw", sw, 18);
    step();
    chk("sweep_done_fall", done, 0);
    chk("sweep_busy_fall", busy, 0);
    chk("sweep_sw_hold", sw, 18);

    // Sweep ending on 8-bit overflow, zero dwell
    sweep_start = 8'd250; sweep_stop = 8'd255; sweep_step = 8'd4; dwell = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovf_sw0", sw, 250);
    step();
    chk("ovf_sw1", sw, 254);
    chk("ovf_no_done", done, 0);
    step();
    chk("ovf_done", done, 1);
    chk("ovf_sw_hold", sw, 254);
    step();
    chk("ovf_idle", busy, 0);

    // Degenerate sweep: zero step, start equals stop
    sweep_start = 8'd5; sweep_stop = 8'd5; sweep_step = 8'd0; dwell = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("degen_sw", sw, 5);
    chk("degen_no_done", done, 0);
    step();
    chk("degen_done", done, 1);
    chk("degen_sw_hold", sw, 5);
    step();
    chk("degen_idle", busy, 0);

    // Calibration, then abort mid-run, then a clean restart
    run_cal(0);
    run_cal(4);
    run_cal(0);

    // Reset during a sweep
    mode = 2'd1; sweep_start = 8'd10; sweep_stop = 8'd20; sweep_step = 8'd4;
    dwell = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midrst_running", busy, 1);
    rst = 1'b1;
    step();
    chk("midrst_sw", sw, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_locked", locked, 0);
    rst = 1'b0;

    // Reserved mode start is ignored
    mode = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("mode3_busy", busy, 0);
    chk("mode3_sw", sw, 0);

    // meas_valid in IDLE is ignored
    meas_count = 16'd5000; meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
    step();
    chk("idle_mv_busy", busy, 0);
    chk("idle_mv_req", meas_req, 0);
    chk("idle_mv_done", done, 0);
    chk("idle_mv_code", cal_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc_dco_tune_ctrl.md
Name: lc_dco_tune_ctrl

Overview:
Parametrised tuning-word controller for the LC DCO switched-capacitor bank. It replaces fixed, hand-driven `sw` codes with three modes: a static code, a timed linear sweep, and an SAR binary-search calibration against an external DCO-edge counter. It sits between the digital configuration registers and the DCO `sw` input, and runs in the reference-clock domain.

Parameters:
SW_WIDTH, 8, width of the DCO tuning word `sw`.
DWELL_WIDTH, 16, width of the sweep dwell counter.
CNT_WIDTH, 16, width of the measured and target edge counts.

Ports:
clk  in  1  reference clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
mode  in  2  0=static, 1=sweep, 2=calibrate, 3=reserved.
start  in  1  one-cycle pulse that launches mode 1 or 2 from IDLE.
abort  in  1  returns to IDLE on the next edge.
static_code  in  SW_WIDTH  code driven in mode 0.
sweep_start  in  SW_WIDTH  first sweep code.
sweep_stop  in  SW_WIDTH  last permissible sweep code (inclusive).
sweep_step  in  SW_WIDTH  sweep increment; 0 is treated as 1.
dwell  in  DWELL_WIDTH  cycles per sweep code; 0 is treated as 1.
target_count  in  CNT_WIDTH  desired edge count per measurement window.
meas_count  in  CNT_WIDTH  result from the external counter.
meas_valid  in  1  one-cycle strobe that qualifies meas_count.
meas_req  out  1  one-cycle pulse requesting a measurement.
sw  out  SW_WIDTH  DCO tuning word (registered).
busy  out  1  high in any non-IDLE state.
done  out  1  one-cycle pulse on normal completion.
locked  out  1  calibration completed; sticky.
cal_code  out  SW_WIDTH  calibration result (registered).

Behaviour:
- Reset values: sw=0, cal_code=0, meas_req=0, busy=0, done=0, locked=0; FSM in IDLE.
- FSM states: IDLE, SWEEP, CAL_SET, CAL_WAIT, FINISH.
- IDLE:
  - mode 0: sw <= static_code every cycle (1-cycle latency).
  - modes 1/2: sw holds its value.
  - start with mode 1 -> SWEEP, sw <= sweep_start, dwell counter cleared.
  - start with mode 2 -> CAL_SET, trial bit = MSB, working code = 0, locked <= 0.
  - start with mode 0 or 3 is ignored.
  - mode and all configuration inputs are sampled only at start; later changes are ignored until IDLE.
- SWEEP:
  - sw holds each code for max(dwell,1) cycles.
  - next = sw + step is computed at SW_WIDTH+1 bits.
  - If next > sweep_stop or next overflows, -> FINISH with sw held at the last code; otherwise sw <= next.
  - If sweep_start > sweep_stop, sw=sweep_start for one dwell, then -> FINISH.
- CAL_SET:
  - sw <= working code | trial bit.
  - Next cycle -> CAL_WAIT with meas_req=1 for exactly that first CAL_WAIT cycle.
- CAL_WAIT:
  - Waits indefinitely for meas_valid; meas_valid is ignored in every other state.
  - On meas_valid, compare unsigned: if meas_count > target_count, keep the trial bit in the working code (higher code = more capacitance = lower frequency); else clear it.
  - If the trial bit was bit 0 -> FINISH; else shift the trial bit right and -> CAL_SET.
  - Total of SW_WIDTH measurements.
  - Result is the largest code with meas_count > target_count, or 0 if none.
- FINISH (one cycle):
  - done=1.
  - In calibrate: sw <= cal_code <= final working code, locked <= 1.
  - Then -> IDLE.
- abort in any non-IDLE state:
  - IDLE on the next edge, sw holds its current value.
  - No done; locked stays 0 if the abort came mid-calibration.
  - abort has priority over meas_valid and dwell expiry in the same cycle.
- rst has priority over all inputs; reset mid-operation returns to the reset values on the next edge.
- locked is cleared only by rst or by a new calibrate start.
- busy=1 in SWEEP, CAL_SET, CAL_WAIT and FINISH.

Test Plan:
- Reset/static: assert rst 3 cycles, then mode=0, static_code=8'd127 -> sw=0 during reset; sw=127 one cycle after release; busy=0, done=0.
- Sweep: mode=1, sweep_start=10, sweep_stop=20, sweep_step=4, dwell=3, pulse start -> sw=10,10,10,14,14,14,18,18,18; done pulses once; sw stays 18; busy falls with done.
- Sweep overflow/degenerate: start=250, stop=255, step=4, dwell=0 -> sw 250, 254 for one cycle each, then done. A second run with step=0, start=stop=5 -> sw=5 for one cycle, then done.
- Calibration: bench model meas_count=1000-2*sw, meas_valid 5 cycles after each meas_req, target=900 -> 8 meas_req pulses; trial sequence 128,64,32,48,56,52,50,49; cal_code=49, sw=49, locked=1, done pulses once.
- Abort: abort during the 4th CAL_WAIT of the calibration run, coincident with meas_valid -> IDLE next cycle; sw holds the trial value 48; no done; locked=0. Restarting then gives the same result of 49.
- Mid-run reset and ignored inputs: rst during SWEEP -> sw=0, busy=0 next edge. start with mode=3 -> no state change. meas_valid pulsed in IDLE -> no effect.
